// File: rtl/alu_pkg.sv
// Package: alu_pkg
//   Shared ALU-control encodings for the MIPS ALU and its adder.
//   Contents:
//     CTL_*       4-bit operation codes driven by the ALU-control decode
//     ctl_is_sub  true for operations that run the adder in subtract mode
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;

    // SLT compares via a-b, so it shares the subtract path with SUB.
    function automatic logic ctl_is_sub(input logic [3:0] ctl);
        return (ctl == CTL_SUB) || (ctl == CTL_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Module: alu_addsub
//   Shared adder for ADD, SUB and SLT: sum = a + (sub ? ~b : b) + sub,
//   modulo 2^WIDTH.
//   Ports:
//     a, b   in   WIDTH  operands
//     sub    in   1      1 selects a-b, 0 selects a+b
//     sum    out  WIDTH  wrapped result
//     sa     out  1      sign bit of a
//     sb     out  1      sign bit of b (the original operand, not inverted)
//     ovf    out  1      signed overflow of the selected operation
//   Configuration: ovf exists only when ALU_OVF_EN is defined.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             sa,
    output logic             sb
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = b ^ {WIDTH{sub}};
        sum   = a + b_eff + WIDTH'(sub);
        sa    = a[WIDTH-1];
        sb    = b[WIDTH-1];
    end

`ifdef ALU_OVF_EN
    // Overflow when the effective operands agree in sign but the result does not.
    always_comb begin
        if (sub)
            ovf = (sa != sb) && (sum[WIDTH-1] != sa);
        else
            ovf = (sa == sb) && (sum[WIDTH-1] != sa);
    end
`endif

endmodule

// File: rtl/mips_alu.sv
// Module: mips_alu
//   32-bit MIPS-style integer ALU with combinational result/zero flag and a
//   one-cycle registered copy for pipelined consumers.
//   Ports:
//     clk    in   1      clock (registered outputs only)
//     rst_n  in   1      synchronous active-low reset
//     ctl    in   4      operation select (alu_pkg::CTL_*)
//     a, b   in   WIDTH  operands
//     out    out  WIDTH  combinational result (0 for unused ctl codes)
//     z      out  1      1 iff out == 0
//     out_q  out  WIDTH  out registered (reset 0)
//     z_q    out  1      z registered (reset 1)
//     ovf    out  1      signed overflow for ADD/SUB   (ALU_OVF_EN only)
//     ovf_q  out  1      ovf registered (reset 0)      (ALU_OVF_EN only)
//   Configuration macro: ALU_OVF_EN adds the ovf/ovf_q ports.
module mips_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic [WIDTH-1:0] out_q,
    output logic             z_q
`ifdef ALU_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    logic [WIDTH-1:0] sum;
    logic             sa;
    logic             sb;
    logic             less;
`ifdef ALU_OVF_EN
    logic             add_ovf;
`endif

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a  (a),
        .b  (b),
        .sub(ctl_is_sub(ctl)),
        .sum(sum),
        .sa (sa),
        .sb (sb)
`ifdef ALU_OVF_EN
        ,
        .ovf(add_ovf)
`endif
    );

    // Signed less-than that survives overflow of a-b: differing signs decide
    // directly, otherwise the difference cannot overflow and its sign is exact.
    always_comb begin
        less = (sa != sb) ? sa : sum[WIDTH-1];
    end

    always_comb begin
        out = '0;
        unique case (ctl)
            CTL_AND: out = a & b;
            CTL_OR:  out = a | b;
            CTL_ADD: out = sum;
            CTL_SUB: out = sum;
            CTL_SLT: out = WIDTH'(less);
            CTL_NOR: out = ~(a | b);
            CTL_XOR: out = a ^ b;
            default: out = '0;
        endcase
        z = (out == '0);
    end

`ifdef ALU_OVF_EN
    always_comb begin
        ovf = ((ctl == CTL_ADD) || (ctl == CTL_SUB)) ? add_ovf : 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            z_q   <= 1'b1;
`ifdef ALU_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            out_q <= out;
            z_q   <= z;
`ifdef ALU_OVF_EN
            ovf_q <= ovf;
`endif
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        z;
    logic [31:0] out_q;
    logic        z_q;
`ifdef ALU_OVF_EN
    logic        ovf;
    logic        ovf_q;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] out;
        logic        z;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        z;
        logic        ovf;
    } vec_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mips_alu #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctl  (ctl),
        .a    (a),
        .b    (b),
        .out  (out),
        .z    (z),
        .out_q(out_q),
        .z_q  (z_q)
`ifdef ALU_OVF_EN
        ,
        .ovf  (ovf),
        .ovf_q(ovf_q)
`endif
    );

    // Behavioural reference using native signed arithmetic on wide integers.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint r;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.out = 32'd0;
        e.ovf = 1'b0;
        case (c)
            4'b0000: e.out = x & y;
            4'b0001: e.out = x | y;
            4'b0010: begin
                e.out = x + y;
                r     = sx + sy;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'b0110: begin
                e.out = x - y;
                r     = sx - sy;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'b0111: e.out = (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: e.out = ~(x | y);
            4'b1101: e.out = x ^ y;
            default: e.out = 32'd0;
        endcase
        e.z = (e.out == 32'd0);
        return e;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        ctl   = 4'b0010;
        a     = 32'd1;
        b     = 32'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_q !== 32'd0 || z_q !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold[%0d]: out_q=%h z_q=%b, expected 00000000 1", i, out_q, z_q);
            end
            checks++;
            if (out !== 32'd3) begin
                errors++;
                $display("FAIL reset_comb[%0d]: out=%h, expected 00000003", i, out);
            end
`ifdef ALU_OVF_EN
            checks++;
            if (ovf_q !== 1'b0) begin
                errors++;
                $display("FAIL reset_ovf_q[%0d]: ovf_q=%b, expected 0", i, ovf_q);
            end
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_q !== 32'd3 || z_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: out_q=%h z_q=%b, expected 00000003 0", out_q, z_q);
        end
    endtask

    task automatic test_directed;
        vec_t v[10];
        exp_t p;
        exp_t e;
        v[0] = '{4'b0111, 32'hfffffff9, 32'h00000006, 32'h00000001, 1'b0, 1'b0};
        v[1] = '{4'b0111, 32'h4a1ba35d, 32'h98782a64, 32'h00000000, 1'b1, 1'b0};
        v[2] = '{4'b0111, 32'h7d8c01d7, 32'hb24d0744, 32'h00000000, 1'b1, 1'b0};
        v[3] = '{4'b0111, 32'ha1a538c4, 32'h2c6f2b94, 32'h00000001, 1'b0, 1'b0};
        v[4] = '{4'b0111, 32'h4270aa12, 32'ha2c98214, 32'h00000000, 1'b1, 1'b0};
        v[5] = '{4'b1101, 32'h000f69b4, 32'h000186a0, 32'h000eef14, 1'b0, 1'b0};
        v[6] = '{4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        v[7] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        v[8] = '{4'b1100, 32'h00000000, 32'h00000000, 32'hffffffff, 1'b0, 1'b0};
        v[9] = '{4'b1111, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                checks++;
                if (out_q !== p.out || z_q !== p.z) begin
                    errors++;
                    $display("FAIL directed_q[%0d]: out_q=%h z_q=%b, expected %h %b", i, out_q, z_q, p.out, p.z);
                end
            end
            ctl = v[i].ctl;
            a   = v[i].a;
            b   = v[i].b;
            #1;
            checks++;
            if (out !== v[i].out || z !== v[i].z) begin
                errors++;
                $display("FAIL directed[%0d] ctl=%b a=%h b=%h: out=%h z=%b, expected %h %b",
                         i, ctl, a, b, out, z, v[i].out, v[i].z);
            end
`ifdef ALU_OVF_EN
            checks++;
            if (ovf !== v[i].ovf) begin
                errors++;
                $display("FAIL directed_ovf[%0d]: ovf=%b, expected %b", i, ovf, v[i].ovf);
            end
`endif
            e.out = v[i].out;
            e.z   = v[i].z;
            e.ovf = v[i].ovf;
            sb_q.push_back(e);
        end
        @(negedge clk);
        p = sb_q.pop_front();
        checks++;
        if (out_q !== p.out || z_q !== p.z) begin
            errors++;
            $display("FAIL directed_q_last: out_q=%h z_q=%b, expected %h %b", out_q, z_q, p.out, p.z);
        end
    endtask

    // Back-to-back sweep: a new operation every cycle, out_q checked one cycle later.
    task automatic test_sweep;
        logic [31:0] grid[8];
        logic [3:0]  ops[10];
        exp_t        p;
        exp_t        e;
        int          n;
        grid = '{32'h00000000, 32'h00000001, 32'hffffffff, 32'h80000000,
                 32'h7fffffff, 32'h00000005, 32'hfffffff9, 32'h80000001};
        ops  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                 4'b1100, 4'b1101, 4'b1111, 4'b0011, 4'b1000};
        n = 10 * 8 * 8 + 80;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                checks++;
                if (out_q !== p.out || z_q !== p.z) begin
                    errors++;
                    $display("FAIL sweep_q[%0d]: out_q=%h z_q=%b, expected %h %b", k, out_q, z_q, p.out, p.z);
                end
`ifdef ALU_OVF_EN
                checks++;
                if (ovf_q !== p.ovf) begin
                    errors++;
                    $display("FAIL sweep_ovf_q[%0d]: ovf_q=%b, expected %b", k, ovf_q, p.ovf);
                end
`endif
            end
            if (k < 640) begin
                ctl = ops[k / 64];
                a   = grid[(k / 8) % 8];
                b   = grid[k % 8];
            end else begin
                ctl = ops[$urandom_range(0, 6)];
                a   = $urandom();
                b   = (k % 3 == 0) ? a : $urandom();
            end
            e = model(ctl, a, b);
            #1;
            checks++;
            if (out !== e.out || z !== e.z) begin
                errors++;
                $display("FAIL sweep[%0d] ctl=%b a=%h b=%h: out=%h z=%b, expected %h %b",
                         k, ctl, a, b, out, z, e.out, e.z);
            end
`ifdef ALU_OVF_EN
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL sweep_ovf[%0d] ctl=%b a=%h b=%h: ovf=%b, expected %b", k, ctl, a, b, ovf, e.ovf);
            end
`endif
            sb_q.push_back(e);
        end
        @(negedge clk);
        p = sb_q.pop_front();
        checks++;
        if (out_q !== p.out || z_q !== p.z) begin
            errors++;
            $display("FAIL sweep_q_last: out_q=%h z_q=%b, expected %h %b", out_q, z_q, p.out, p.z);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ctl   = 4'b0010;
        a     = 32'd1;
        b     = 32'd2;
        test_reset();
        test_directed();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
